// File: rtl/dmg_oam_dma.sv
// dmg_oam_dma: OAM DMA controller. Owns FF46 and copies LEN bytes from the
// effective source page into PPU OAM, one byte per ce tick. The source page
// is {base,8'h00}; bases in E0..FF are folded down by 8'h20 (echo RAM).
//
// Ports:
//   clk, rst        system clock, synchronous active-low reset
//   ce              M-cycle enable (one clk wide, may be held high)
//   reg_write       FF46 write strobe, reg_d_in write data
//   reg_d_rd        FF46 readback (last written base)
//   dma_active      DMA owns the bus; src_addr valid, src_data returned
//   src_addr        source read address (16'h0000 when idle)
//   src_data        bus read data, sampled on ce during transfer
//   oam_addr        OAM byte index, oam_d_wr write data, oam_write strobe
//   done            one-clk pulse together with the final oam_write
module dmg_oam_dma #(
    parameter int unsigned LEN         = 160,
    parameter int unsigned START_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        reg_write,
    input  logic [7:0]  reg_d_in,
    output logic [7:0]  reg_d_rd,
    output logic        dma_active,
    output logic [15:0] src_addr,
    input  logic [7:0]  src_data,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_d_wr,
    output logic        oam_write,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_XFER
    } state_t;

    localparam logic [7:0] LAST = 8'(LEN - 1);
    localparam logic [7:0] DLY  = 8'(START_DELAY);

    state_t     state, state_n;
    logic [7:0] base, base_n;
    logic [7:0] idx, idx_n;
    logic [7:0] ctr, ctr_n;
    logic [7:0] oam_addr_n, oam_d_wr_n;
    logic       oam_write_n, done_n;
    logic [7:0] eff;

    assign eff        = (base >= 8'hE0) ? base - 8'h20 : base;
    assign reg_d_rd   = base;
    assign dma_active = (state == S_XFER);
    assign src_addr   = dma_active ? {eff, idx} : '0;

    always_comb begin
        state_n     = state;
        base_n      = base;
        idx_n       = idx;
        ctr_n       = ctr;
        oam_addr_n  = oam_addr;
        oam_d_wr_n  = oam_d_wr;
        oam_write_n = 1'b0;
        done_n      = 1'b0;
        // A register write restarts from any state and swallows a coincident
        // ce, so a byte sampled on that same clk never reaches OAM.
        if (reg_write) begin
            base_n  = reg_d_in;
            idx_n   = '0;
            ctr_n   = DLY;
            state_n = (START_DELAY == 0) ? S_XFER : S_START;
        end else if (ce) begin
            case (state)
                S_START: begin
                    ctr_n = ctr - 8'd1;
                    if (ctr <= 8'd1) state_n = S_XFER;
                end
                S_XFER: begin
                    oam_write_n = 1'b1;
                    oam_addr_n  = idx;
                    oam_d_wr_n  = src_data;
                    if (idx == LAST) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        idx_n = idx + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            base      <= 8'hFF;
            idx       <= '0;
            ctr       <= '0;
            oam_addr  <= '0;
            oam_d_wr  <= '0;
            oam_write <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            base      <= base_n;
            idx       <= idx_n;
            ctr       <= ctr_n;
            oam_addr  <= oam_addr_n;
            oam_d_wr  <= oam_d_wr_n;
            oam_write <= oam_write_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_dmg_oam_dma.sv
// tb_dmg_oam_dma: bench for dmg_oam_dma. Two instances share the stimulus:
// u1 with START_DELAY=1 and u0 with START_DELAY=0. Expected outputs come from
// a ce-counting model of the transfer rules plus a short hand-built table.
module tb_dmg_oam_dma;

    localparam int LEN  = 160;
    localparam int MAXC = 2048;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0;
    logic        reg_write = 1'b0;
    logic [7:0]  reg_d_in = 8'h00;

    logic [7:0]  rd1, rd0, oa1, oa0, od1, od0, sd1, sd0;
    logic        act1, act0, ow1, ow0, dn1, dn0;
    logic [15:0] src1, src0;

    logic [7:0]  mem [65536];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign sd1 = mem[src1];
    assign sd0 = mem[src0];

    dmg_oam_dma #(.LEN(LEN), .START_DELAY(1)) u1 (
        .clk(clk), .rst(rst), .ce(ce), .reg_write(reg_write), .reg_d_in(reg_d_in),
        .reg_d_rd(rd1), .dma_active(act1), .src_addr(src1), .src_data(sd1),
        .oam_addr(oa1), .oam_d_wr(od1), .oam_write(ow1), .done(dn1)
    );

    dmg_oam_dma #(.LEN(LEN), .START_DELAY(0)) u0 (
        .clk(clk), .rst(rst), .ce(ce), .reg_write(reg_write), .reg_d_in(reg_d_in),
        .reg_d_rd(rd0), .dma_active(act0), .src_addr(src0), .src_data(sd0),
        .oam_addr(oa0), .oam_d_wr(od0), .oam_write(ow0), .done(dn0)
    );

    task automatic chk(input string nm, input int c, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", nm, c, got, exp);
        end
    endtask

    // ---------------- table-driven directed vectors (START_DELAY=1 instance)
    typedef struct {
        logic rst; logic wr; logic ce; logic [7:0] wd;
        logic [7:0] rd; logic act; logic [15:0] src; logic ow;
        logic [7:0] oa; logic [7:0] od; logic dn; logic cko;
    } vec_t;

    vec_t tbl [14];

    // ---------------- scenario schedule and model expectations
    int         n;
    logic       s_rst [MAXC];
    logic       s_wr  [MAXC];
    logic       s_ce  [MAXC];
    logic [7:0] s_wd  [MAXC];

    logic        e_act [2][MAXC];
    logic [15:0] e_src [2][MAXC];
    logic        e_wr  [2][MAXC];
    logic [7:0]  e_oa  [2][MAXC];
    logic [7:0]  e_od  [2][MAXC];
    logic        e_dn  [2][MAXC];
    logic [7:0]  e_rd  [2][MAXC];

    function automatic logic [7:0] page_of(input logic [7:0] b);
        return (b >= 8'hE0) ? b - 8'h20 : b;
    endfunction

    task automatic clr(input int len);
        n = len;
        for (int c = 0; c < len; c++) begin
            s_rst[c] = 1'b1; s_wr[c] = 1'b0; s_ce[c] = 1'b0; s_wd[c] = 8'h00;
        end
        s_rst[0] = 1'b0;
        s_rst[1] = 1'b0;
    endtask

    // After a write, the first sd qualifying ce ticks are start delay, the next
    // LEN each move one byte; a write or reset ends any transfer in progress.
    task automatic build_exp(input int k, input int sd);
        logic [7:0] b;
        int         cnt;
        int         idx;
        bit         armed;
        b = 8'hFF; cnt = 0; armed = 0;
        for (int c = 0; c < n; c++) begin
            e_wr[k][c] = 1'b0; e_dn[k][c] = 1'b0; e_oa[k][c] = 8'h00; e_od[k][c] = 8'h00;
            if (!s_rst[c]) begin
                b = 8'hFF; armed = 0; cnt = 0;
            end else if (s_wr[c]) begin
                b = s_wd[c]; armed = 1; cnt = 0;
            end else if (s_ce[c] && armed && cnt < sd + LEN) begin
                cnt++;
                if (cnt > sd) begin
                    idx = cnt - sd - 1;
                    e_wr[k][c] = 1'b1;
                    e_oa[k][c] = 8'(idx);
                    e_od[k][c] = mem[{page_of(b), 8'(idx)}];
                    e_dn[k][c] = (idx == LEN - 1);
                end
            end
            e_rd[k][c]  = b;
            e_act[k][c] = armed && cnt >= sd && cnt < sd + LEN;
            e_src[k][c] = e_act[k][c] ? {page_of(b), 8'(cnt - sd)} : 16'h0000;
        end
    endtask

    task automatic check_one(input string nm, input int k, input int c,
                             input logic [7:0] rd, input logic act, input logic [15:0] src,
                             input logic ow, input logic [7:0] oa, input logic [7:0] od,
                             input logic dn);
        string p;
        p = $sformatf("%s.u%0d", nm, 1 - k);
        chk({p, " reg_d_rd"}, c, 32'(rd), 32'(e_rd[k][c]));
        chk({p, " dma_active"}, c, 32'(act), 32'(e_act[k][c]));
        chk({p, " src_addr"}, c, 32'(src), 32'(e_src[k][c]));
        chk({p, " oam_write"}, c, 32'(ow), 32'(e_wr[k][c]));
        chk({p, " done"}, c, 32'(dn), 32'(e_dn[k][c]));
        if (e_wr[k][c]) begin
            chk({p, " oam_addr"}, c, 32'(oa), 32'(e_oa[k][c]));
            chk({p, " oam_d_wr"}, c, 32'(od), 32'(e_od[k][c]));
        end
    endtask

    task automatic run_scn(input string nm);
        build_exp(0, 1);
        build_exp(1, 0);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rst = s_rst[c]; reg_write = s_wr[c]; reg_d_in = s_wd[c]; ce = s_ce[c];
            @(posedge clk);
            #1;
            check_one(nm, 0, c, rd1, act1, src1, ow1, oa1, od1, dn1);
            check_one(nm, 1, c, rd0, act0, src0, ow0, oa0, od0, dn0);
        end
        @(negedge clk);
        reg_write = 1'b0; ce = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'hC000 + i] = 8'(i) ^ 8'h5A;

        //            rst wr  ce  wd     rd     act src      ow  oa     od     dn  cko
        tbl[0]  = '{1'b0,1'b0,1'b0,8'h00, 8'hFF,1'b0,16'h0000,1'b0,8'h00,8'h00,1'b0,1'b1};
        tbl[1]  = '{1'b0,1'b0,1'b1,8'h00, 8'hFF,1'b0,16'h0000,1'b0,8'h00,8'h00,1'b0,1'b1};
        tbl[2]  = '{1'b1,1'b0,1'b1,8'h00, 8'hFF,1'b0,16'h0000,1'b0,8'h00,8'h00,1'b0,1'b0};
        tbl[3]  = '{1'b1,1'b1,1'b1,8'hC0, 8'hC0,1'b0,16'h0000,1'b0,8'h00,8'h00,1'b0,1'b0};
        tbl[4]  = '{1'b1,1'b0,1'b0,8'h00, 8'hC0,1'b0,16'h0000,1'b0,8'h00,8'h00,1'b0,1'b0};
        tbl[5]  = '{1'b1,1'b0,1'b1,8'h00, 8'hC0,1'b1,16'hC000,1'b0,8'h00,8'h00,1'b0,1'b0};
        tbl[6]  = '{1'b1,1'b0,1'b0,8'h00, 8'hC0,1'b1,16'hC000,1'b0,8'h00,8'h00,1'b0,1'b0};
        tbl[7]  = '{1'b1,1'b0,1'b1,8'h00, 8'hC0,1'b1,16'hC001,1'b1,8'h00,8'h5A,1'b0,1'b1};
        tbl[8]  = '{1'b1,1'b0,1'b1,8'h00, 8'hC0,1'b1,16'hC002,1'b1,8'h01,8'h5B,1'b0,1'b1};
        tbl[9]  = '{1'b1,1'b0,1'b0,8'h00, 8'hC0,1'b1,16'hC002,1'b0,8'h00,8'h00,1'b0,1'b0};
        tbl[10] = '{1'b1,1'b1,1'b1,8'h10, 8'h10,1'b0,16'h0000,1'b0,8'h00,8'h00,1'b0,1'b0};
        tbl[11] = '{1'b1,1'b0,1'b0,8'h00, 8'h10,1'b0,16'h0000,1'b0,8'h00,8'h00,1'b0,1'b0};
        tbl[12] = '{1'b1,1'b0,1'b1,8'h00, 8'h10,1'b1,16'h1000,1'b0,8'h00,8'h00,1'b0,1'b0};
        tbl[13] = '{1'b0,1'b0,1'b1,8'h00, 8'hFF,1'b0,16'h0000,1'b0,8'h00,8'h00,1'b0,1'b1};

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            rst = tbl[i].rst; reg_write = tbl[i].wr; ce = tbl[i].ce; reg_d_in = tbl[i].wd;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d reg_d_rd", i), i, 32'(rd1), 32'(tbl[i].rd));
            chk($sformatf("tbl%0d dma_active", i), i, 32'(act1), 32'(tbl[i].act));
            chk($sformatf("tbl%0d src_addr", i), i, 32'(src1), 32'(tbl[i].src));
            chk($sformatf("tbl%0d oam_write", i), i, 32'(ow1), 32'(tbl[i].ow));
            chk($sformatf("tbl%0d done", i), i, 32'(dn1), 32'(tbl[i].dn));
            if (tbl[i].cko) begin
                chk($sformatf("tbl%0d oam_addr", i), i, 32'(oa1), 32'(tbl[i].oa));
                chk($sformatf("tbl%0d oam_d_wr", i), i, 32'(od1), 32'(tbl[i].od));
            end
        end

        // Full copy from C0, ce every 4 clks.
        clr(700);
        s_wr[3] = 1'b1; s_wd[3] = 8'hC0;
        for (int c = 4; c < 700; c++) s_ce[c] = (c % 4 == 0);
        run_scn("T2");

        // Echo-page fold: FE reads from DE.
        clr(400);
        s_wr[3] = 1'b1; s_wd[3] = 8'hFE;
        for (int c = 4; c < 400; c++) s_ce[c] = (c % 2 == 0);
        run_scn("T3");

        // Restart to page 80 mid-copy, coinciding with a ce.
        clr(900);
        s_wr[3] = 1'b1; s_wd[3] = 8'hC0;
        for (int c = 4; c < 900; c++) s_ce[c] = (c % 4 == 0);
        s_wr[208] = 1'b1; s_wd[208] = 8'h80;
        run_scn("T4");

        // Reset during a copy.
        clr(200);
        s_wr[3] = 1'b1; s_wd[3] = 8'hC0;
        for (int c = 4; c < 200; c++) s_ce[c] = (c % 4 == 0);
        s_rst[86] = 1'b0;
        run_scn("T5");

        // ce held high.
        clr(220);
        for (int c = 2; c < 220; c++) s_ce[c] = 1'b1;
        s_wr[3] = 1'b1; s_wd[3] = 8'hC0;
        run_scn("T6");

        // Randomized schedules: ce density, restarts, echo bases, rare resets.
        for (int r = 0; r < 3; r++) begin
            int pce;
            pce = 20 + 35 * r;
            clr(1500);
            s_wr[4] = 1'b1; s_wd[4] = 8'($urandom);
            for (int c = 5; c < 1500; c++) begin
                s_ce[c] = ($urandom_range(0, 99) < pce);
                if ($urandom_range(0, 399) == 0) begin
                    s_wr[c] = 1'b1;
                    s_wd[c] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(224, 255)) : 8'($urandom);
                end
                if ($urandom_range(0, 1499) == 0) s_rst[c] = 1'b0;
            end
            run_scn($sformatf("R%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
